// File: rtl/dma_block_engine.sv
// Block-transfer DMA between on-chip main memory and the CNN datapath: a strided read
// into a parallel lane buffer, or a strided streaming write with valid/ready back-pressure.
module dma_block_engine #(
  parameter int    DATA_WIDTH = 16,
  parameter int    ADDR_WIDTH = 16,
  parameter int    MEM_DEPTH  = 2500,
  parameter int    MAX_BURST  = 25,
  parameter string INIT_FILE  = ""
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            rw,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [ADDR_WIDTH-1:0]           stride,
  input  logic [$clog2(MAX_BURST+1)-1:0]  length,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  output logic [MAX_BURST*DATA_WIDTH-1:0] block_out,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int LW  = $clog2(MAX_BURST + 1);
  localparam int AW  = ADDR_WIDTH + $clog2(MAX_BURST) + 1;
  localparam int MIW = $clog2(MEM_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  typedef logic [DATA_WIDTH-1:0] mem_t [MEM_DEPTH];

  // Power-up image: identity pattern.
  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < MEM_DEPTH; i++) m[i] = DATA_WIDTH'(i);
    return m;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = mem_init();

  logic [1:0]            state_reg;
  logic [LW-1:0]         len_reg;
  logic [LW-1:0]         k_reg;
  logic [AW-1:0]         addr_reg;
  logic [AW-1:0]         stride_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic                  wr_ready_reg;
  logic [DATA_WIDTH-1:0] lane_reg [MAX_BURST];

  logic [LW-1:0]         len_clamped;
  logic                  in_range;
  logic                  last_beat;
  logic                  beat_accept;
  logic [MIW-1:0]        mem_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [AW-1:0]         addr_next;

  assign len_clamped = (length > LW'(MAX_BURST)) ? LW'(MAX_BURST) : length;
  assign in_range    = addr_reg < AW'(MEM_DEPTH);
  // Also true for L=0, so an empty burst finishes on its first active edge.
  assign last_beat   = ({1'b0, k_reg} + (LW+1)'(1)) >= {1'b0, len_reg};
  assign beat_accept = (state_reg == ST_WRITE) && wr_valid && wr_ready_reg;
  assign mem_idx     = addr_reg[MIW-1:0];
  assign rd_word     = mem[mem_idx];
  assign addr_next   = addr_reg + stride_reg;

  // Memory has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && beat_accept && in_range) mem[mem_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      k_reg        <= '0;
      addr_reg     <= '0;
      stride_reg   <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      wr_ready_reg <= 1'b0;
      for (int i = 0; i < MAX_BURST; i++) lane_reg[i] <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            len_reg    <= len_clamped;
            k_reg      <= '0;
            addr_reg   <= AW'(base_addr);
            stride_reg <= AW'(stride);
            err_reg    <= 1'b0;
            busy_reg   <= 1'b1;
            if (rw) begin
              state_reg <= ST_READ;
              for (int i = 0; i < MAX_BURST; i++) lane_reg[i] <= '0;
            end else begin
              state_reg    <= ST_WRITE;
              wr_ready_reg <= (len_clamped != '0);
            end
          end
        end
        ST_READ: begin
          if (k_reg < len_reg) begin
            lane_reg[k_reg] <= in_range ? rd_word : '0;
            if (!in_range) err_reg <= 1'b1;
            k_reg    <= k_reg + LW'(1);
            addr_reg <= addr_next;
          end
          if (last_beat) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (len_reg == '0) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (beat_accept) begin
            if (!in_range) err_reg <= 1'b1;
            k_reg    <= k_reg + LW'(1);
            addr_reg <= addr_next;
            if (last_beat) begin
              done_reg     <= 1'b1;
              busy_reg     <= 1'b0;
              wr_ready_reg <= 1'b0;
              state_reg    <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_BURST; gi++) begin : g_lane
      assign block_out[gi*DATA_WIDTH +: DATA_WIDTH] = lane_reg[gi];
    end
  endgenerate

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign err      = err_reg;
  assign wr_ready = wr_ready_reg;

endmodule

// File: tb/tb_dma_block_engine.sv
// Self-checking bench for dma_block_engine: directed bursts plus random bursts, checked
// against a word-array memory model and address arithmetic a_k = base + k*stride.
module tb_dma_block_engine;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 2500;
  localparam int MB    = 25;
  localparam int LW    = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           rw;
  logic [AW-1:0]  base_addr;
  logic [AW-1:0]  stride;
  logic [LW-1:0]  length;
  logic [DW-1:0]  wr_data;
  logic           wr_valid;
  logic           wr_ready;
  logic [MB*DW-1:0] block_out;
  logic           busy;
  logic           done;
  logic           err;

  dma_block_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .MAX_BURST(MB), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .base_addr(base_addr), .stride(stride),
    .length(length), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .block_out(block_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0]    ref_mem [DEPTH];
  logic [MB*DW-1:0] last_block;

  task automatic chk(input string tag, input logic [MB*DW-1:0] obs, input logic [MB*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete burst; poke>=0 re-asserts start during a read to show it is ignored.
  task automatic run_burst(input bit r, input int base, input int strd, input int len,
                           input int gap_max, input bit fixed_data, input int poke);
    int L;
    int a;
    int cycles;
    logic exp_err;
    logic [MB*DW-1:0] exp_blk;
    L = (len > MB) ? MB : len;
    exp_err = 1'b0;
    exp_blk = '0;
    for (int k = 0; k < L; k++) begin
      a = base + k * strd;
      if (a >= DEPTH) exp_err = 1'b1;
      else if (r) exp_blk[k*DW +: DW] = ref_mem[a];
    end
    start = 1'b1; rw = r; base_addr = AW'(base); stride = AW'(strd); length = LW'(len);
    tick();
    start = 1'b0;
    chk("busy_launch", busy, 1);
    chk("err_clear", err, 0);
    cycles = 0;
    if (r) begin
      while (cycles < 100) begin
        if (cycles == poke) begin
          start = 1'b1; rw = 1'b0; base_addr = 16'd7; length = 5'd3;
        end else begin
          start = 1'b0;
        end
        tick();
        cycles++;
        if (done === 1'b1) break;
        chk("busy_mid", busy, 1);
      end
      start = 1'b0;
      chk("rd_latency", cycles, (L == 0) ? 1 : L);
      chk("rd_block", block_out, exp_blk);
      last_block = exp_blk;
    end else begin
      for (int k = 0; k < L; k++) begin
        repeat ($urandom_range(0, gap_max)) tick();
        chk("wr_ready", wr_ready, 1);
        wr_valid = 1'b1;
        wr_data  = fixed_data ? DW'(10 + k) : DW'($urandom);
        a = base + k * strd;
        if (a < DEPTH) ref_mem[a] = wr_data;
        tick();
        wr_valid = 1'b0;
        if (k < L - 1) chk("wr_done_early", done, 0);
      end
      if (L == 0) begin
        chk("wr_ready_len0", wr_ready, 0);
        tick();
      end
      chk("wr_done", done, 1);
      chk("wr_ready_end", wr_ready, 0);
      chk("wr_block_hold", block_out, last_block);
    end
    chk("busy_done", busy, 0);
    chk("err", err, exp_err);
    tick();
    chk("done_pulse", done, 0);
    chk("err_hold", err, exp_err);
    $display("burst rw=%0d base=%0d stride=%0d len=%0d cycles=%0d err=%0d", r, base, strd, len, cycles, exp_err);
  endtask

  initial begin
    logic seen_done;
    logic [5*DW-1:0] exp_wr;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i);
    last_block = '0;
    rst = 1'b1; start = 1'b0; rw = 1'b0; base_addr = '0; stride = '0; length = '0;
    wr_data = '0; wr_valid = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_block", block_out, '0);
    rst = 1'b0;
    tick();

    run_burst(1, 10, 1, 25, 0, 0, -1);
    run_burst(1, 3, 100, 4, 0, 0, -1);
    run_burst(0, 50, 2, 3, 3, 1, -1);
    run_burst(1, 50, 1, 5, 0, 0, -1);
    exp_wr = {16'hC, 16'd53, 16'hB, 16'd51, 16'hA};
    chk("wr_then_rd", block_out[5*DW-1:0], exp_wr);
    run_burst(1, 2490, 1, 25, 0, 0, -1);
    run_burst(1, 0, 1, 0, 0, 0, -1);
    run_burst(0, 100, 1, 0, 0, 0, -1);
    run_burst(1, 98, 1, 4, 0, 0, -1);
    run_burst(1, 7, 3, 31, 0, 0, -1);

    // Reset on the 5th cycle of a 25-word read
    start = 1'b1; rw = 1'b1; base_addr = 16'd0; stride = 16'd1; length = 5'd25;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_block = '0;
    chk("abort_block", block_out, '0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    chk("abort_wr_ready", wr_ready, 0);
    seen_done = 1'b0;
    repeat (30) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("abort_no_done", seen_done, 0);
    $display("reset abort of read burst");

    run_burst(1, 0, 1, 25, 0, 0, 3);
    run_burst(0, 2495, 2, 6, 2, 0, -1);

    for (int n = 0; n < 30; n++) begin
      run_burst(1'($urandom_range(0, 1)), $urandom_range(0, 2600), $urandom_range(0, 120),
                $urandom_range(0, 31), 3, 0, -1);
    end
    for (int n = 0; n < 6; n++) begin
      run_burst(1, $urandom_range(0, 2480), $urandom_range(1, 4), 25, 0, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
